// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO port controller: arbitrates icache fetches and LSB loads/stores,
// sequencing each transaction little-endian one byte per cycle.
module mem_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int IO_HI_BIT  = 17
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  rollback,
   input  logic                  icache_enable,
   input  logic [ADDR_WIDTH-1:0] icache_addr,
   output logic                  icache_valid,
   output logic [31:0]           icache_dout,
   input  logic                  lsb_enable,
   input  logic                  lsb_wr,
   input  logic [1:0]            lsb_size,
   input  logic [ADDR_WIDTH-1:0] lsb_addr,
   input  logic [31:0]           lsb_din,
   output logic                  lsb_valid,
   output logic [31:0]           lsb_dout,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_wr,
   input  logic                  io_buffer_full
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [2:0]            len_q, len_d;
   logic                  last_lsb_q, last_lsb_d;
   logic                  own_lsb_q, own_lsb_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           data_q, data_d;
   logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
   logic                  mem_wr_q, mem_wr_d;
   logic [7:0]            mem_dout_q, mem_dout_d;
   logic [31:0]           icache_dout_q, icache_dout_d;
   logic [31:0]           lsb_dout_q, lsb_dout_d;

   logic                  ic_req, take_lsb, take_ic;
   logic [ADDR_WIDTH-1:0] wr_a;
   logic [1:0]            bidx;
   logic [2:0]            req_len;

   function automatic logic is_io(input logic [ADDR_WIDTH-1:0] a);
      return a[IO_HI_BIT -: 2] == 2'b11;
   endfunction

   always_comb begin
      // rollback suppresses a new fetch grant in the same edge it is seen
      ic_req   = icache_enable & ~rollback;
      take_lsb = lsb_enable & (~ic_req | ~last_lsb_q);
      take_ic  = ic_req & ~take_lsb;
      case (lsb_size)
         2'd0:    req_len = 3'd1;
         2'd1:    req_len = 3'd2;
         default: req_len = 3'd4;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      len_d         = len_q;
      last_lsb_d    = last_lsb_q;
      own_lsb_d     = own_lsb_q;
      addr_d        = addr_q;
      data_d        = data_q;
      mem_a_d       = mem_a_q;
      mem_wr_d      = 1'b0;
      mem_dout_d    = mem_dout_q;
      icache_dout_d = icache_dout_q;
      lsb_dout_d    = lsb_dout_q;
      wr_a          = addr_q + ADDR_WIDTH'(cnt_q);
      bidx          = 2'(cnt_q - 3'd2);

      case (state_q)
         S_IDLE: begin
            if (take_lsb || take_ic) begin
               own_lsb_d  = take_lsb;
               last_lsb_d = take_lsb;
               addr_d     = take_lsb ? lsb_addr : icache_addr;
               len_d      = take_lsb ? req_len : 3'd4;
               data_d     = (take_lsb && lsb_wr) ? lsb_din : 32'd0;
               cnt_d      = 3'd0;
               if (take_lsb && lsb_wr) begin
                  state_d = S_WRITE;
                  if (!(is_io(lsb_addr) && io_buffer_full)) begin
                     mem_a_d    = lsb_addr;
                     mem_dout_d = lsb_din[7:0];
                     mem_wr_d   = 1'b1;
                     cnt_d      = 3'd1;
                  end
               end else begin
                  state_d = S_READ;
                  mem_a_d = addr_d;
                  cnt_d   = 3'd1;
               end
            end
         end
         S_READ: begin
            if (rollback && !own_lsb_q) begin
               state_d = S_IDLE;
            end else begin
               if (cnt_q < len_q)
                  mem_a_d = wr_a;
               // RAM returns each byte two edges after its address edge
               if (cnt_q >= 3'd2)
                  data_d[{bidx, 3'b000} +: 8] = mem_din;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == len_q + 3'd1) begin
                  state_d = S_DONE;
                  if (own_lsb_q) lsb_dout_d = data_d;
                  else           icache_dout_d = data_d;
               end
            end
         end
         S_WRITE: begin
            if (cnt_q == len_q) begin
               state_d = S_DONE;
            end else if (!(is_io(wr_a) && io_buffer_full)) begin
               mem_a_d    = wr_a;
               mem_dout_d = data_q[{cnt_q[1:0], 3'b000} +: 8];
               mem_wr_d   = 1'b1;
               cnt_d      = cnt_q + 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= 3'd0;
         len_q         <= 3'd0;
         last_lsb_q    <= 1'b0;
         own_lsb_q     <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
         mem_a_q       <= '0;
         mem_wr_q      <= 1'b0;
         mem_dout_q    <= '0;
         icache_dout_q <= '0;
         lsb_dout_q    <= '0;
      end else if (rdy) begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         len_q         <= len_d;
         last_lsb_q    <= last_lsb_d;
         own_lsb_q     <= own_lsb_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         mem_a_q       <= mem_a_d;
         mem_wr_q      <= mem_wr_d;
         mem_dout_q    <= mem_dout_d;
         icache_dout_q <= icache_dout_d;
         lsb_dout_q    <= lsb_dout_d;
      end
   end

   // a fetch flushed while in DONE must not report completion
   assign icache_valid = rdy && (state_q == S_DONE) && !own_lsb_q && !rollback;
   assign lsb_valid    = rdy && (state_q == S_DONE) && own_lsb_q;
   assign icache_dout  = icache_dout_q;
   assign lsb_dout     = lsb_dout_q;
   assign mem_a        = mem_a_q;
   assign mem_wr       = mem_wr_q;
   assign mem_dout     = mem_dout_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single owner of the byte-wide RAM/IO port. Arbitrates between the instruction cache (4-byte fetch) and the load/store buffer (1/2/4-byte load or store).
- Sequences each transaction byte by byte, little-endian. Assembles or splits words.
- Returns one valid pulse per completed transaction to the requester that issued it.

Parameters:
- ADDR_WIDTH, 32, width of byte addresses on all ports.
- IO_HI_BIT, 17, address bits [IO_HI_BIT:IO_HI_BIT-1]==2'b11 select the IO space.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- rdy  input  1  global ready; low freezes all state.
- rollback  input  1  pipeline flush.
- icache_enable  input  1  fetch request, held until icache_valid.
- icache_addr  input  ADDR_WIDTH  fetch address.
- icache_valid  output  1  one-cycle done pulse.
- icache_dout  output  32  fetched instruction.
- lsb_enable  input  1  data request, held until lsb_valid.
- lsb_wr  input  1  1=store, 0=load.
- lsb_size  input  2  0=1B, 1=2B, 2=4B; 3 is treated as 4B.
- lsb_addr  input  ADDR_WIDTH  data address.
- lsb_din  input  32  store data, low bytes used.
- lsb_valid  output  1  one-cycle done pulse.
- lsb_dout  output  32  load data, zero-extended.
- mem_din  input  8  RAM read byte.
- mem_dout  output  8  RAM write byte.
- mem_a  output  ADDR_WIDTH  RAM byte address.
- mem_wr  output  1  1=write.
- io_buffer_full  input  1  IO write buffer full.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, byte counters=0, last_grant=ICACHE.
  - All outputs 0, including mem_wr, both valids and both douts.
- rdy=0: no register changes.
- States:
  - IDLE: one of READ, WRITE is entered.
  - READ, WRITE: active transaction, described below.
  - DONE: the valid pulse is high for exactly this one cycle. Requests are ignored in DONE so the same held request is never re-accepted. DONE always returns to IDLE.
- Arbitration (IDLE only):
  - If only one requester is enabled, it is granted.
  - If both are enabled, the requester not equal to last_grant wins (round-robin).
  - last_grant updates on grant.
  - A grant latches addr, size, wr and store data; requester inputs are not re-sampled afterwards.
  - ICache is always a 4-byte read.
- RAM timing:
  - mem_a and mem_wr are registered.
  - A read byte appears on mem_din in the cycle after its address is registered. It is captured on the following edge.
- READ of N bytes, accept edge E0:
  - Edges E0..E(N-1) drive mem_a=addr+0..addr+N-1 with mem_wr=0.
  - Edges E2..E(N+1) capture bytes into [7:0], [15:8], ….
  - E(N+1) enters DONE and presents the data.
  - Latency: 4-byte valid at cycle after E5; 1-byte valid after E2.
- WRITE of N bytes:
  - Edges E0..E(N-1) drive mem_a=addr+k, mem_dout=din[8k+7:8k], mem_wr=1.
  - E N enters DONE with mem_wr=0.
  - IO stall: if the next byte's address is IO and io_buffer_full=1, that edge drives mem_wr=0 and does not advance. The byte is issued on the first edge with io_buffer_full=0.
- mem_wr is 0 in IDLE, READ and DONE.
- Address arithmetic is modulo 2^ADDR_WIDTH; addr+k wraps.
- rollback=1:
  - An ICache transaction in READ/DONE is aborted to IDLE with no icache_valid.
  - LSB transactions always complete. The LSB never issues speculative requests.
  - rollback in IDLE blocks any ICache grant that edge.
- Reset mid-transaction aborts immediately; a partially written word is not reverted.
- The valid outputs are mutually exclusive.
- douts hold their last value outside DONE.

Test Plan:
- ICache-only fetch: RAM[0x100..0x103]=13,05,00,00, icache_enable at 0x100.
  - Expect mem_a=0x100..0x103 on four consecutive cycles.
  - Expect icache_valid for one cycle, 5 cycles after accept, with icache_dout=0x00000513.
- Byte load then halfword store:
  - lsb_size=0 load at 0x2000 (RAM=0xFF) -> lsb_dout=0x000000FF, valid after 2 cycles.
  - Store lsb_size=1, din=0xABCD at 0x2002 -> mem_wr with (0x2002,CD) then (0x2003,AB), then lsb_valid.
- Simultaneous requests, last_grant=ICACHE:
  - LSB is served first, then ICache.
  - With both requests held continuously, grants alternate. No request is accepted during DONE.
- IO store stall: store 1B 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles.
  - mem_wr stays 0 for 3 cycles.
  - Then a single write of (0x30000,0x41), then lsb_valid.
- rollback mid-fetch:
  - Assert rollback on cycle 2 of an ICache read -> no icache_valid, state IDLE next cycle.
  - A pending LSB load is granted on the following edge.
- Async reset and rdy:
  - Assert rst between clock edges during a WRITE -> mem_wr=0 and valids=0 immediately.
  - Deassert rst; with rdy=0 and requests held, nothing is granted and mem_a is unchanged.
